lj16_frame_deserializer: RTL and testbench



---
 rtl/lj16_frame_deserializer.sv | 97 +++++++++
 tb/tb_lj16_frame_deserializer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lj16_frame_deserializer.sv
// lj16_frame_deserializer: 16-bit left-justified serial stream to L/R parallel frames through a 2-deep FIFO.
// Ports: bck/rst_n clock and async active-low reset; data/lrck serial input; out_l/out_r/out_valid/out_ready
// frame output handshake; frame_err short-slot pulse; locked alignment status; overrun_cnt dropped frames.
module lj16_frame_deserializer #(
  parameter logic LEFT_POL  = 1'b1,
  parameter int   SLOT_BITS = 16
) (
  input  logic        bck,
  input  logic        rst_n,
  input  logic        data,
  input  logic        lrck,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        locked,
  output logic [7:0]  overrun_cnt
);
  localparam logic [4:0] FULL = 5'(SLOT_BITS);
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  state_t      state, state_d;
  logic        primed, lrck_q, lr_edge, done, push, err, latch_l, pop, wr, wp, rp;
  logic [4:0]  cnt;
  logic [15:0] sh, left_w;
  logic [1:0]  occ;
  logic [31:0] mem [2];
  assign lr_edge = primed && (lrck != lrck_q);
  assign done = cnt == FULL;
  assign pop = out_valid && out_ready;
  // a push into a full FIFO only lands when the head leaves in the same cycle
  assign wr = push && (occ != 2'd2 || pop);
  assign out_valid = occ != 2'd0;
  assign {out_l, out_r} = mem[rp];
  always_comb begin
    state_d = state;
    push = 1'b0;
    err = 1'b0;
    latch_l = 1'b0;
    if (lr_edge)
      case (state)
        SYNC: state_d = (lrck == LEFT_POL) ? LEFT : SYNC;
        LEFT: begin
          latch_l = done;
          err = !done;
          state_d = done ? RIGHT : SYNC;
        end
        RIGHT: begin
          push = done;
          err = !done;
          state_d = LEFT;
        end
        default: state_d = SYNC;
      endcase
  end
  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      primed <= 1'b0;
      lrck_q <= 1'b0;
      cnt <= 5'd0;
      sh <= 16'd0;
      left_w <= 16'd0;
      frame_err <= 1'b0;
      locked <= 1'b0;
      overrun_cnt <= 8'd0;
      mem[0] <= 32'd0;
      mem[1] <= 32'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      state <= state_d;
      primed <= 1'b1;
      lrck_q <= lrck;
      // the edge cycle carries the new channel's MSB; bits past the slot width are ignored
      if (lr_edge) begin
        sh <= {15'd0, data};
        cnt <= 5'd1;
      end else if (cnt < FULL) begin
        sh <= {sh[14:0], data};
        cnt <= cnt + 5'd1;
      end
      if (latch_l) left_w <= sh;
      frame_err <= err;
      if (err) locked <= 1'b0;
      else if (push) locked <= 1'b1;
      if (wr) begin
        mem[wp] <= {left_w, sh};
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      occ <= occ + 2'(wr) - 2'(pop);
      if (push && !wr && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_lj16_frame_deserializer.sv
// tb_lj16_frame_deserializer: directed LJ stream stimulus with a queue scoreboard checked by a separate monitor.
module tb_lj16_frame_deserializer;
  localparam logic LP = 1'b1;
  logic        bck = 1'b0;
  logic        rst_n, data, lrck, out_ready;
  logic [15:0] out_l, out_r;
  logic        out_valid, frame_err, locked;
  logic [7:0]  overrun_cnt;
  logic [31:0] q [$];
  logic [31:0] exp_f;
  int          total = 0;
  int          bad = 0;
  int          errs = 0;
  int          errs0;
  lj16_frame_deserializer #(.LEFT_POL(LP), .SLOT_BITS(16)) dut (
    .bck(bck), .rst_n(rst_n), .data(data), .lrck(lrck),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .locked(locked), .overrun_cnt(overrun_cnt)
  );
  always #5 bck = ~bck;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic send_slot(input logic lv, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge bck);
      lrck = lv;
      data = (i < 16) ? w[15-i] : i[0];
    end
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(LP, l, 16);
    send_slot(!LP, r, 16);
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge bck);
    chk("drain_left", q.size(), 0);
  endtask
  always @(negedge bck) begin
    #4;
    if (rst_n) begin
      if (frame_err) errs++;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pop got=%h exp=none", {out_l, out_r});
        end else begin
          exp_f = q.pop_front();
          if ({out_l, out_r} !== exp_f) begin
            bad++;
            $display("FAIL frame got=%h exp=%h", {out_l, out_r}, exp_f);
          end
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    lrck = !LP;
    data = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge bck);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_l", out_l, 0);
    chk("rst_r", out_r, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovr", overrun_cnt, 0);
    @(negedge bck);
    rst_n = 1'b1;
    repeat (3) @(negedge bck);
    q.push_back({16'hA55A, 16'h1234});
    send_frame(16'hA55A, 16'h1234);
    q.push_back({16'hBEEF, 16'hC0DE});
    send_slot(LP, 16'hBEEF, 24);
    chk("basic_locked", locked, 1);
    chk("basic_errs", errs, 0);
    send_slot(!LP, 16'hC0DE, 24);
    send_slot(LP, 16'h1111, 10);
    send_slot(!LP, 16'h2222, 16);
    chk("short_errs", errs, 1);
    chk("short_locked", locked, 0);
    q.push_back({16'h5678, 16'h9ABC});
    send_frame(16'h5678, 16'h9ABC);
    chk("long_errs", errs, 1);
    q.push_back({16'h0101, 16'h1010});
    q.push_back({16'h0202, 16'h2020});
    fork
      begin
        repeat (3) @(negedge bck);
        out_ready = 1'b0;
      end
    join_none
    send_frame(16'h0101, 16'h1010);
    chk("relock", locked, 1);
    send_frame(16'h0202, 16'h2020);
    send_frame(16'h0303, 16'h3030);
    send_frame(16'h0404, 16'h4040);
    send_slot(LP, 16'h0505, 16);
    chk("ovr_cnt", overrun_cnt, 2);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_head", {out_l, out_r}, {16'h0101, 16'h1010});
    send_slot(!LP, 16'h5050, 16);
    q.push_back({16'h0505, 16'h5050});
    fork
      begin
        @(negedge bck);
        out_ready = 1'b1;
        @(negedge bck);
        out_ready = 1'b0;
      end
    join_none
    send_slot(LP, 16'h0606, 16);
    chk("sim_ovr", overrun_cnt, 2);
    chk("sim_head", {out_l, out_r}, {16'h0202, 16'h2020});
    q.push_back({16'h0606, 16'h6060});
    out_ready = 1'b1;
    send_slot(!LP, 16'h6060, 16);
    send_slot(LP, 16'h0000, 16);
    drain();
    chk("sim_ovr_end", overrun_cnt, 2);
    send_slot(LP, 16'hFFFF, 6);
    @(negedge bck);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_l", out_l, 0);
    chk("mid_r", out_r, 0);
    chk("mid_locked", locked, 0);
    chk("mid_ovr", overrun_cnt, 0);
    errs0 = errs;
    repeat (2) @(negedge bck);
    rst_n = 1'b1;
    send_slot(!LP, 16'hDEAD, 16);
    q.push_back({16'hCAFE, 16'hF00D});
    send_frame(16'hCAFE, 16'hF00D);
    send_slot(LP, 16'h0000, 16);
    drain();
    chk("post_rst_errs", errs, errs0);
    chk("post_rst_locked", locked, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
